// File: rtl/dog_extrema_detect.sv
// dog_extrema_detect: 3x3x3 scale-space extremum detector over a raster stream of three DoG planes
module dog_extrema_detect #(
    parameter int WIDE   = 230,
    parameter int HIGN   = 235,
    parameter int DW     = 8,
    parameter int CNT_DW = 16,
    parameter int THRESH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in,
    input  logic signed [DW-1:0]     dog1,
    input  logic signed [DW-1:0]     dog2,
    input  logic signed [DW-1:0]     dog3,
    output logic                     valid_out,
    output logic                     key_flag,
    output logic        [CNT_DW-1:0] key_x,
    output logic        [CNT_DW-1:0] key_y,
    output logic signed [DW-1:0]     key_val
);
    localparam int AW = (WIDE > 1) ? $clog2(WIDE) : 1;
    localparam logic [DW:0] THR = (DW+1)'(THRESH);
    localparam logic [CNT_DW-1:0] COL_LAST = CNT_DW'(WIDE - 1);
    localparam logic [CNT_DW-1:0] ROW_LAST = CNT_DW'(HIGN - 1);
    localparam logic [CNT_DW-1:0] TWO = CNT_DW'(2);

    logic signed [DW-1:0] px [3];
    logic signed [DW-1:0] lb1_q [3][WIDE];
    logic signed [DW-1:0] lb2_q [3][WIDE];
    logic signed [DW-1:0] win_q [3][3][3];
    logic signed [DW-1:0] win_d [3][3][3];
    logic [CNT_DW-1:0] col_q, col_d, row_q, row_d;
    logic [CNT_DW-1:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d;
    logic s1_valid_q, s1_valid_d;
    logic valid_out_q, valid_out_d, key_flag_q, key_flag_d;
    logic [CNT_DW-1:0] key_x_q, key_x_d, key_y_q, key_y_d;
    logic signed [DW-1:0] key_val_q, key_val_d;
    logic [AW-1:0] col_idx;
    logic signed [DW-1:0] c;
    logic [DW:0] c_ext, c_abs;
    logic is_max, is_min, cand;

    assign px[0]     = dog1;
    assign px[1]     = dog2;
    assign px[2]     = dog3;
    assign col_idx   = col_q[AW-1:0];
    assign valid_out = valid_out_q;
    assign key_flag  = key_flag_q;
    assign key_x     = key_x_q;
    assign key_y     = key_y_q;
    assign key_val   = key_val_q;

    // Stage 1: advance raster counters, shift windows with {row-2,row-1,current} column, tag interior centres
    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        s1_valid_d = 1'b0;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        win_d      = win_q;
        if (valid_in) begin
            col_d      = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
            row_d      = (col_q != COL_LAST) ? row_q : (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            s1_valid_d = (col_q >= TWO) && (row_q >= TWO);
            s1_x_d     = col_q - 1'b1;
            s1_y_d     = row_q - 1'b1;
            for (int p = 0; p < 3; p++) begin
                for (int r = 0; r < 3; r++) begin
                    win_d[p][r][0] = win_q[p][r][1];
                    win_d[p][r][1] = win_q[p][r][2];
                end
                win_d[p][0][2] = lb2_q[p][col_idx];
                win_d[p][1][2] = lb1_q[p][col_idx];
                win_d[p][2][2] = px[p];
            end
        end
    end

    // Stage 2 compare: centre must strictly beat all 26 neighbours and clear the magnitude threshold
    always_comb begin
        c      = win_q[1][1][1];
        is_max = 1'b1;
        is_min = 1'b1;
        for (int p = 0; p < 3; p++)
            for (int r = 0; r < 3; r++)
                for (int k = 0; k < 3; k++)
                    if (!(p == 1 && r == 1 && k == 1)) begin
                        is_max &= (c > win_q[p][r][k]);
                        is_min &= (c < win_q[p][r][k]);
                    end
        c_ext = {c[DW-1], c};
        c_abs = c_ext[DW] ? -c_ext : c_ext;
        cand  = (is_max | is_min) && (c_abs >= THR);
    end

    // Stage 2 outputs: strobe per interior pixel, coordinates and value hold between strobes
    always_comb begin
        valid_out_d = s1_valid_q;
        key_flag_d  = s1_valid_q & cand;
        key_x_d     = s1_valid_q ? s1_x_q : key_x_q;
        key_y_d     = s1_valid_q ? s1_y_q : key_y_q;
        key_val_d   = s1_valid_q ? c : key_val_q;
    end

    // Line buffers: previous row moves to row-2, current pixel becomes row-1 (contents after reset are don't-care)
    always_ff @(posedge clk) begin
        if (valid_in)
            for (int p = 0; p < 3; p++) begin
                lb2_q[p][col_idx] <= lb1_q[p][col_idx];
                lb1_q[p][col_idx] <= px[p];
            end
    end

    // Pipeline state registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q       <= '0;
            row_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            valid_out_q <= 1'b0;
            key_flag_q  <= 1'b0;
            key_x_q     <= '0;
            key_y_q     <= '0;
            key_val_q   <= '0;
            for (int p = 0; p < 3; p++)
                for (int r = 0; r < 3; r++)
                    for (int k = 0; k < 3; k++)
                        win_q[p][r][k] <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            s1_valid_q  <= s1_valid_d;
            s1_x_q      <= s1_x_d;
            s1_y_q      <= s1_y_d;
            valid_out_q <= valid_out_d;
            key_flag_q  <= key_flag_d;
            key_x_q     <= key_x_d;
            key_y_q     <= key_y_d;
            key_val_q   <= key_val_d;
            win_q       <= win_d;
        end
    end
endmodule

// File: tb/tb_dog_extrema_detect.sv
// tb_dog_extrema_detect: directed and gapped-stream checks of the DoG extremum detector on an 8x6 frame
module tb_dog_extrema_detect;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int DW = 8;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic valid_in = 1'b0;
    logic signed [DW-1:0] dog1 = '0, dog2 = '0, dog3 = '0;
    logic valid_out, key_flag;
    logic [CW-1:0] key_x, key_y;
    logic signed [DW-1:0] key_val;

    always #5 clk = ~clk;

    dog_extrema_detect #(.WIDE(W), .HIGN(H), .DW(DW), .CNT_DW(CW), .THRESH(2)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in),
        .dog1(dog1), .dog2(dog2), .dog3(dog3),
        .valid_out(valid_out), .key_flag(key_flag),
        .key_x(key_x), .key_y(key_y), .key_val(key_val)
    );

    typedef struct {int x; int y; int flag; int val; int due;} exp_t;

    int f [3][H][W];
    exp_t exp_q[$];
    exp_t e_m;
    int errors = 0, checks = 0, cyc = 0;
    int res_cnt = 0, flag_cnt = 0, fx = 0, fy = 0, fv = 0;

    task automatic check(input string tag, input int obs, input int want);
        checks++;
        if (obs != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, want);
        end
    endtask

    function automatic int model_flag(input int x, input int y);
        int cv, v, a;
        bit mx, mn;
        cv = f[1][y][x];
        mx = 1'b1;
        mn = 1'b1;
        for (int p = 0; p < 3; p++)
            for (int dy = -1; dy <= 1; dy++)
                for (int dx = -1; dx <= 1; dx++)
                    if (!(p == 1 && dy == 0 && dx == 0)) begin
                        v = f[p][y+dy][x+dx];
                        if (!(cv > v)) mx = 1'b0;
                        if (!(cv < v)) mn = 1'b0;
                    end
        a = (cv < 0) ? -cv : cv;
        return ((mx || mn) && a >= 2) ? 1 : 0;
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int y = 1; y < H - 1; y++)
            for (int x = 1; x < W - 1; x++)
                n += model_flag(x, y);
        return n;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_valid", int'(valid_out), 0);
            check("rst_flag", int'(key_flag), 0);
            check("rst_x", int'(key_x), 0);
            check("rst_y", int'(key_y), 0);
            check("rst_val", int'(key_val), 0);
        end else if (valid_out) begin
            if (exp_q.size() == 0)
                check("unexpected_out", 1, 0);
            else begin
                e_m = exp_q.pop_front();
                check("key_x", int'(key_x), e_m.x);
                check("key_y", int'(key_y), e_m.y);
                check("key_flag", int'(key_flag), e_m.flag);
                check("key_val", int'(key_val), e_m.val);
                check("latency", cyc, e_m.due);
            end
            res_cnt++;
            if (key_flag) begin
                flag_cnt++;
                fx = int'(key_x);
                fy = int'(key_y);
                fv = int'(key_val);
            end
        end else
            check("idle_flag", int'(key_flag), 0);
    end

    task automatic idle();
        valid_in = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_px(input int x, input int y, input int gap);
        while (int'($urandom_range(99)) < gap) idle();
        valid_in = 1'b1;
        dog1 = DW'(f[0][y][x]);
        dog2 = DW'(f[1][y][x]);
        dog3 = DW'(f[2][y][x]);
        if (x >= 2 && y >= 2)
            exp_q.push_back('{x - 1, y - 1, model_flag(x - 1, y - 1), f[1][y-1][x-1], cyc + 2});
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic send_px(input int npx, input int gap);
        for (int i = 0; i < npx; i++) drive_px(i % W, i / W, gap);
    endtask

    task automatic clr();
        for (int p = 0; p < 3; p++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    f[p][y][x] = 0;
    endtask

    task automatic rnd();
        for (int p = 0; p < 3; p++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    f[p][y][x] = int'($urandom_range(8)) - 4;
    endtask

    task automatic run_frame(input string tag, input int gap, input int nflag, input int ex, input int ey, input int ev);
        res_cnt = 0;
        flag_cnt = 0;
        fx = -1;
        fy = -1;
        fv = -999;
        send_px(W * H, gap);
        repeat (4) idle();
        check({tag, "_results"}, res_cnt, (W - 2) * (H - 2));
        check({tag, "_flags"}, flag_cnt, nflag);
        if (ex >= 0) begin
            check({tag, "_fx"}, fx, ex);
            check({tag, "_fy"}, fy, ey);
            check({tag, "_fv"}, fv, ev);
        end
        check({tag, "_pending"}, exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clr();
        dog2 = 8'sd50;
        for (int i = 0; i < 8; i++) begin
            valid_in = ~valid_in;
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        rst = 1'b1;
        idle();

        clr();
        run_frame("zero", 0, 0, -1, 0, 0);

        clr(); f[1][3][4] = 20;
        run_frame("max20", 20, 1, 4, 3, 20);
        clr(); f[1][3][4] = -30;
        run_frame("min30", 0, 1, 4, 3, -30);
        clr(); f[1][3][4] = -128;
        run_frame("min128", 0, 1, 4, 3, -128);

        clr(); f[1][3][4] = 20; f[2][2][3] = 20;
        run_frame("tie_d3", 0, 0, -1, 0, 0);
        clr(); f[1][3][4] = 20; f[0][4][5] = 21;
        run_frame("big_d1", 0, 0, -1, 0, 0);
        clr();
        for (int p = 0; p < 3; p++)
            for (int y = 2; y <= 4; y++)
                for (int x = 3; x <= 5; x++)
                    f[p][y][x] = 19;
        f[1][3][4] = 20;
        run_frame("nb19", 0, 1, 4, 3, 20);

        clr(); f[1][3][4] = 1;
        run_frame("thr1", 0, 0, -1, 0, 0);
        clr(); f[1][3][4] = -2;
        run_frame("thr_m2", 0, 1, 4, 3, -2);
        clr(); f[1][3][0] = 20;
        run_frame("border_l", 0, 0, -1, 0, 0);
        clr(); f[1][3][7] = 20;
        run_frame("border_r", 0, 0, -1, 0, 0);

        rnd();
        run_frame("rand_a", 35, model_count(), -1, 0, 0);
        rnd();
        run_frame("rand_b", 35, model_count(), -1, 0, 0);

        rnd();
        send_px(3 * W + 4, 35);
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            valid_in = ~valid_in;
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        rst = 1'b1;
        rnd();
        run_frame("post_rst", 35, model_count(), -1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
